// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - round-robin arbiter sharing the reg_file write port between two writeback requesters
module rf_write_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] chk_a,
  input  logic [ADDR_W-1:0] chk_b,
  output logic              hazard_a,
  output logic              hazard_b,
  output logic [ADDR_W-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic              rf_we,
  output logic [CNT_W-1:0]  grant0_cnt,
  output logic [CNT_W-1:0]  grant1_cnt
);

  typedef enum logic {
    PREF0 = 1'b0,
    PREF1 = 1'b1
  } pref_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  pref_t state;
  pref_t state_nxt;

  // Priority state register; reset favours the ALU writeback path.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PREF0;
    end else begin
      state <= state_nxt;
    end
  end

  // Grant decode and next priority: the winner hands the tie-break to the other side.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    state_nxt  = state;
    if (!rst) begin
      req0_ready = req0_valid && (!req1_valid || (state == PREF0));
      req1_ready = req1_valid && (!req0_valid || (state == PREF1));
    end
    if (req0_ready) begin
      state_nxt = PREF1;
    end else if (req1_ready) begin
      state_nxt = PREF0;
    end
  end

  // Stage the accepted write for one cycle; address/data hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we <= 1'b0;
      rf_wa <= '0;
      rf_wd <= '0;
    end else if (req0_ready) begin
      rf_we <= 1'b1;
      rf_wa <= req0_addr;
      rf_wd <= req0_data;
    end else if (req1_ready) begin
      rf_we <= 1'b1;
      rf_wa <= req1_addr;
      rf_wd <= req1_data;
    end else begin
      rf_we <= 1'b0;
    end
  end

  // Saturating per-requester transfer counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant0_cnt <= '0;
      grant1_cnt <= '0;
    end else begin
      if (req0_ready && (grant0_cnt != CNT_MAX)) begin
        grant0_cnt <= grant0_cnt + CNT_W'(1);
      end
      if (req1_ready && (grant1_cnt != CNT_MAX)) begin
        grant1_cnt <= grant1_cnt + CNT_W'(1);
      end
    end
  end

  // A read of the staged register would see the stale value until the commit edge.
  assign hazard_a = rf_we && (rf_wa == chk_a);
  assign hazard_b = rf_we && (rf_wa == chk_b);

endmodule
